// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, PC step, reset vector and
// the fetch engine state encoding.
package riscv_pkg;
   localparam int XLEN    = 32;
   localparam int ILEN    = 32;
   localparam int PC_STEP = 4;

   localparam logic [XLEN-1:0] RESET_VECTOR = '0;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DRAIN
   } fetch_state_t;
endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory request/response channel plus the
// decode-side instruction handshake.
interface if_fetch_ctrl_if #(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter int ILEN = riscv_pkg::ILEN
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [ILEN-1:0] imem_rsp_data;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_pc;
   logic [ILEN-1:0] if_instr;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output if_valid, if_pc, if_instr,
      input  if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  if_valid, if_pc, if_instr,
      output if_ready
   );
endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: loads either pc+STEP (wrapping) or a word-aligned
// redirect target when ld is asserted.
module fetch_pc_reg #(
   parameter int              XLEN     = 32,
   parameter int              STEP     = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ld,
   input  logic            sel_redir,
   input  logic [XLEN-1:0] redir_pc,
   output logic [XLEN-1:0] pc
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= RESET_PC;
      else if (ld)
         pc <= sel_redir ? {redir_pc[XLEN-1:2], 2'b00} : pc + XLEN'(STEP);
   end
endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, one-entry
// instruction buffer to decode, redirect with stale-response draining.
module if_fetch_ctrl #(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter int              ILEN     = riscv_pkg::ILEN,
   parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_VECTOR
) (
   input  logic            clk,
   input  logic            rst_n,
   if_fetch_ctrl_if.master bus,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc_out
);
   import riscv_pkg::*;

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic            pc_ld;
   logic            if_valid_q;
   logic [XLEN-1:0] if_pc_q;
   logic [ILEN-1:0] if_instr_q;

   // pc advances only on a live response; a redirect always wins
   assign pc_ld = redirect_valid | ((state == WAIT) & bus.imem_rsp_valid);

   fetch_pc_reg #(
      .XLEN     (XLEN),
      .STEP     (PC_STEP),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld        (pc_ld),
      .sel_redir (redirect_valid),
      .redir_pc  (redirect_pc),
      .pc        (pc)
   );

   assign pc_out             = pc;
   assign bus.imem_req_addr  = pc;
   assign bus.imem_req_valid = (state == REQ);
   assign bus.if_valid       = if_valid_q;
   assign bus.if_pc          = if_pc_q;
   assign bus.if_instr       = if_instr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               // a request accepted alongside a redirect is already stale
               if (bus.imem_req_ready)
                  state <= redirect_valid ? DRAIN : WAIT;
            end
            WAIT: begin
               if (bus.imem_rsp_valid) begin
                  if (redirect_valid) begin
                     state <= REQ;
                  end else begin
                     if_instr_q <= bus.imem_rsp_data;
                     if_pc_q    <= pc;
                     if_valid_q <= 1'b1;
                     state      <= HOLD;
                  end
               end else if (redirect_valid) begin
                  state <= DRAIN;
               end
            end
            HOLD: begin
               if (redirect_valid || bus.if_ready) begin
                  if_valid_q <= 1'b0;
                  state      <= REQ;
               end
            end
            DRAIN: begin
               if (bus.imem_rsp_valid)
                  state <= REQ;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: transaction-level model of fetch order, buffered
// instruction and stale-response dropping, driven by directed and random steps.
module tb_if_fetch_ctrl;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc_out;

   always #5 clk = ~clk;

   if_fetch_ctrl_if bus ();

   if_fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc_out         (pc_out)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   int total = 0;
   int bad   = 0;

   // model state: expected fetch PC, outstanding imem request, buffered entry
   logic [31:0] exp_pc;
   bit          started;
   bit          outstanding;
   int          cnt;
   int          mem_lat;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   int          epoch;
   int          out_epoch;
   ent_t        q[$];
   logic [31:0] req_log[$];
   logic [31:0] pres_pc[$];
   int          pres_cyc[$];
   int          cyc_n = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_pc      = RESET_VECTOR;
      started     = 1'b0;
      outstanding = 1'b0;
      cnt         = 0;
      epoch       = 0;
      q.delete();
   endtask

   task automatic cyc(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
      bit          rsp;
      bit          s_req;
      bit          s_ifv;
      bit          exp_req;
      logic [31:0] s_addr;
      rsp = outstanding && (cnt == 0);
      bus.imem_req_ready = rdy;
      bus.if_ready       = irdy;
      redirect_valid     = redir;
      redirect_pc        = rpc;
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? out_data : $urandom;
      s_req  = bus.imem_req_valid;
      s_addr = bus.imem_req_addr;
      s_ifv  = bus.if_valid;
      @(posedge clk);
      cyc_n++;
      if (rsp) begin
         outstanding = 1'b0;
         if (!redir && out_epoch == epoch) begin
            q.push_back('{pc: out_addr, ins: out_data});
            exp_pc = exp_pc + 32'd4;
         end
      end else if (outstanding) begin
         cnt--;
      end
      if (s_req && rdy) begin
         outstanding = 1'b1;
         out_addr    = s_addr;
         out_data    = $urandom;
         out_epoch   = epoch;
         cnt         = mem_lat;
         req_log.push_back(s_addr);
      end
      if (s_ifv && irdy && q.size() != 0) begin
         pres_pc.push_back(q[0].pc);
         pres_cyc.push_back(cyc_n);
         void'(q.pop_front());
      end
      if (redir) begin
         epoch++;
         q.delete();
         exp_pc = rpc & 32'hFFFF_FFFC;
      end
      started = 1'b1;
      #1;
      bus.imem_rsp_valid = 1'b0;
      exp_req = started && !outstanding && (q.size() == 0);
      chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
      if (exp_req) chk("req_addr", bus.imem_req_addr, exp_pc);
      chk("pc_out", pc_out, exp_pc);
      chk("if_valid", 32'(bus.if_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("if_pc", bus.if_pc, q[0].pc);
         chk("if_instr", bus.if_instr, q[0].ins);
      end
   endtask

   // reset asserted between clock edges; outputs must clear without an edge
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_req_addr", bus.imem_req_addr, RESET_VECTOR);
      chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
      chk("rst_if_pc", bus.if_pc, 32'd0);
      chk("rst_if_instr", bus.if_instr, 32'd0);
      chk("rst_pc_out", pc_out, RESET_VECTOR);
      bus.imem_req_ready = 1'b0;
      bus.if_ready       = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      redirect_valid     = 1'b0;
      redirect_pc        = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int          n;
      int          m;
      logic [31:0] held;
      bus.imem_req_ready = 1'b0;
      bus.if_ready       = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      redirect_valid     = 1'b0;
      redirect_pc        = '0;
      mem_lat            = 0;
      model_reset();

      // 1: sequential fetch, single-cycle memory
      do_reset();
      repeat (10) cyc(1, 1, 0, 0);
      chk("t1_nreq", 32'(req_log.size() >= 3), 32'd1);
      chk("t1_npres", 32'(pres_pc.size() >= 3), 32'd1);
      if (req_log.size() >= 3) begin
         chk("t1_req0", req_log[0], 32'h0);
         chk("t1_req1", req_log[1], 32'h4);
         chk("t1_req2", req_log[2], 32'h8);
      end
      if (pres_pc.size() >= 3) begin
         chk("t1_pres0", pres_pc[0], 32'h0);
         chk("t1_pres1", pres_pc[1], 32'h4);
         chk("t1_pres2", pres_pc[2], 32'h8);
         chk("t1_gap01", 32'(pres_cyc[1] - pres_cyc[0]), 32'd3);
         chk("t1_gap12", 32'(pres_cyc[2] - pres_cyc[1]), 32'd3);
      end

      // 2: decode backpressure at pc 0x4
      do_reset();
      repeat (4) cyc(1, 1, 0, 0);
      for (int i = 0; i < 10 && !bus.if_valid; i++) cyc(1, 0, 0, 0);
      chk("t2_valid", 32'(bus.if_valid), 32'd1);
      chk("t2_pc", bus.if_pc, 32'h4);
      held = bus.if_instr;
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 0, 0);
         chk("t2_hold_valid", 32'(bus.if_valid), 32'd1);
         chk("t2_hold_pc", bus.if_pc, 32'h4);
         chk("t2_hold_instr", bus.if_instr, held);
         chk("t2_hold_noreq", 32'(bus.imem_req_valid), 32'd0);
      end
      n = req_log.size();
      mem_lat = 2;
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      chk("t2_next_req", (req_log.size() > n) ? req_log[n] : 32'hDEAD_BEEF, 32'h8);

      // 3: redirect while the 0x8 request is outstanding
      chk("t3_outstanding", 32'(outstanding), 32'd1);
      cyc(1, 1, 1, 32'h100);
      mem_lat = 0;
      m = pres_pc.size();
      for (int i = 0; i < 12 && pres_pc.size() == m; i++) cyc(1, 1, 0, 0);
      chk("t3_req", (req_log.size() > n + 1) ? req_log[n+1] : 32'hDEAD_BEEF, 32'h100);
      chk("t3_pres", (pres_pc.size() > m) ? pres_pc[m] : 32'hDEAD_BEEF, 32'h100);

      // 4a: redirect coincident with the response
      for (int i = 0; i < 12 && !outstanding; i++) cyc(1, 1, 0, 0);
      chk("t4a_outstanding", 32'(outstanding), 32'd1);
      n = req_log.size();
      m = pres_pc.size();
      cyc(1, 1, 1, 32'h203);
      for (int i = 0; i < 12 && pres_pc.size() == m; i++) cyc(1, 1, 0, 0);
      chk("t4a_req", (req_log.size() > n) ? req_log[n] : 32'hDEAD_BEEF, 32'h200);
      chk("t4a_pres", (pres_pc.size() > m) ? pres_pc[m] : 32'hDEAD_BEEF, 32'h200);

      // 4b: redirect together with decode accept
      for (int i = 0; i < 12 && !bus.if_valid; i++) cyc(1, 0, 0, 0);
      chk("t4b_valid", 32'(bus.if_valid), 32'd1);
      cyc(1, 1, 1, 32'h203);
      n = req_log.size();
      m = pres_pc.size();
      for (int i = 0; i < 12 && pres_pc.size() == m; i++) cyc(1, 1, 0, 0);
      chk("t4b_req", (req_log.size() > n) ? req_log[n] : 32'hDEAD_BEEF, 32'h200);
      chk("t4b_pres", (pres_pc.size() > m) ? pres_pc[m] : 32'hDEAD_BEEF, 32'h200);

      // 5: wrap-around of pc+4
      cyc(0, 1, 1, 32'hFFFF_FFFC);
      n = req_log.size();
      for (int i = 0; i < 20 && req_log.size() < n + 2; i++) cyc(1, 1, 0, 0);
      chk("t5_req_top", (req_log.size() > n) ? req_log[n] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      chk("t5_req_wrap", (req_log.size() > n + 1) ? req_log[n+1] : 32'hDEAD_BEEF, 32'h0);

      // 6: async reset in the middle of WAIT
      mem_lat = 2;
      for (int i = 0; i < 12 && !outstanding; i++) cyc(1, 1, 0, 0);
      chk("t6_outstanding", 32'(outstanding), 32'd1);
      do_reset();
      mem_lat = 0;
      n = req_log.size();
      for (int i = 0; i < 6 && req_log.size() == n; i++) cyc(1, 1, 0, 0);
      chk("t6_first_req", (req_log.size() > n) ? req_log[n] : 32'hDEAD_BEEF, RESET_VECTOR);

      // random traffic against the model
      m = pres_pc.size();
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] rpc;
         case ($urandom_range(0, 2))
            0:       rpc = $urandom;
            1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: rpc = 32'($urandom_range(0, 255));
         endcase
         mem_lat = $urandom_range(0, 3);
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 11) == 0, rpc);
      end
      chk("rand_progress", 32'(pres_pc.size() > m + 50), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
